// File: rtl/ika87ad_busmem.sv
// ika87ad_busmem: external memory model for the IKA87AD bus.
// It provides the clock-enable prescaler, an ALE address latch, registered reads,
// write commit on the WR_n rising edge with a write-protected ROM window, and a loader port.
// Define IKA87AD_BUSMEM_STATS_EN to add the saturating o_RD_CNT and o_WR_CNT access counters.
module ika87ad_busmem #(
   parameter int AW       = 9,
   parameter int PRESCALE = 4,
   parameter int ROM_LO   = 0,
   parameter int ROM_HI   = 255
) (
   input  logic          i_EMUCLK,
   input  logic          i_RESET_n,
   output logic          o_PCEN,
   input  logic          i_ALE,
   input  logic          i_RD_n,
   input  logic          i_WR_n,
   input  logic [15:0]   i_A,
   input  logic [7:0]    i_CPU_DO,
   output logic [7:0]    o_CPU_DI,
   output logic          o_DI_OE,
   input  logic          i_LD_EN,
   input  logic          i_LD_WE,
   input  logic [AW-1:0] i_LD_ADDR,
   input  logic [7:0]    i_LD_DATA,
   output logic          o_LD_ACK,
`ifdef IKA87AD_BUSMEM_STATS_EN
   output logic [15:0]   o_RD_CNT,
   output logic [15:0]   o_WR_CNT,
`endif
   output logic          o_WPROT
);

   localparam int            CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
   localparam logic [AW-1:0] LO      = AW'(ROM_LO);
   localparam logic [AW-1:0] SPAN    = AW'(ROM_HI - ROM_LO);
   localparam logic          PROT_EN = (ROM_LO <= ROM_HI);

   logic [7:0]    mem [2**AW];
   logic [CW-1:0] cnt;
   logic [AW-1:0] latch;
   logic [AW-1:0] rom_off;
   logic [7:0]    wdata;
   logic          wr_hist;
   logic          rd_ok;
   logic          commit;
   logic          in_rom;
   logic          ld_wr;

   assign rd_ok   = !i_RD_n && i_WR_n && !i_LD_EN;
   assign commit  = !wr_hist && i_WR_n && !i_LD_EN;
   // A wrapped offset from ROM_LO keeps the window test a single compare.
   assign rom_off = latch - LO;
   assign in_rom  = PROT_EN && (rom_off <= SPAN);
   assign ld_wr   = i_LD_EN && i_LD_WE;

   // The prescaler counts 0..PRESCALE-1 and flags the last count one cycle later.
   always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         cnt    <= '0;
         o_PCEN <= 1'b0;
      end else begin
         cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
         o_PCEN <= (cnt == LAST);
      end
   end

   // The address latch, registered read path, write capture and status pulses.
   always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         latch    <= '0;
         wdata    <= '0;
         wr_hist  <= 1'b1;
         o_CPU_DI <= 8'hFF;
         o_DI_OE  <= 1'b0;
         o_LD_ACK <= 1'b0;
         o_WPROT  <= 1'b0;
      end else begin
         latch    <= i_ALE ? i_A[AW-1:0] : latch;
         wdata    <= !i_WR_n ? i_CPU_DO : wdata;
         wr_hist  <= i_WR_n;
         o_CPU_DI <= rd_ok ? mem[latch] : 8'hFF;
         o_DI_OE  <= rd_ok;
         o_LD_ACK <= ld_wr;
         o_WPROT  <= commit && in_rom;
      end
   end

   // The array is not reset, so the loaded image survives a core reset.
   always_ff @(posedge i_EMUCLK) begin
      if (ld_wr) mem[i_LD_ADDR] <= i_LD_DATA;
      else if (commit && !in_rom) mem[latch] <= wdata;
   end

`ifdef IKA87AD_BUSMEM_STATS_EN
   logic rd_hist;

   // The access counters saturate at all-ones. Protected writes still count as commits.
   always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         rd_hist  <= 1'b1;
         o_RD_CNT <= '0;
         o_WR_CNT <= '0;
      end else begin
         rd_hist  <= i_RD_n;
         o_RD_CNT <= (rd_hist && rd_ok && o_RD_CNT != 16'hFFFF) ? o_RD_CNT + 1'b1 : o_RD_CNT;
         o_WR_CNT <= (commit && o_WR_CNT != 16'hFFFF) ? o_WR_CNT + 1'b1 : o_WR_CNT;
      end
   end
`endif

endmodule

// File: tb/tb_ika87ad_busmem.sv
// tb_ika87ad_busmem: directed self-checking bench for ika87ad_busmem.
// It also checks the counters when IKA87AD_BUSMEM_STATS_EN is defined.
module tb_ika87ad_busmem;

   logic       i_EMUCLK = 1'b0;
   logic       i_RESET_n = 1'b0;
   logic       i_ALE = 1'b0, i_RD_n = 1'b1, i_WR_n = 1'b1;
   logic [15:0] i_A = '0;
   logic [7:0] i_CPU_DO = '0;
   logic       i_LD_EN = 1'b0, i_LD_WE = 1'b0;
   logic [8:0] i_LD_ADDR = '0;
   logic [7:0] i_LD_DATA = '0;
   logic       o_PCEN, o_DI_OE, o_LD_ACK, o_WPROT;
   logic [7:0] o_CPU_DI;
   logic       p1_PCEN, p1_DI_OE, p1_LD_ACK, p1_WPROT;
   logic [7:0] p1_CPU_DI;
`ifdef IKA87AD_BUSMEM_STATS_EN
   logic [15:0] o_RD_CNT, o_WR_CNT, p1_RD_CNT, p1_WR_CNT;
`endif
   int n_chk = 0;
   int n_err = 0;

   always #5 i_EMUCLK = ~i_EMUCLK;

   ika87ad_busmem #(.AW(9), .PRESCALE(4), .ROM_LO(0), .ROM_HI(255)) u_dut (
      .i_EMUCLK(i_EMUCLK), .i_RESET_n(i_RESET_n), .o_PCEN(o_PCEN), .i_ALE(i_ALE),
      .i_RD_n(i_RD_n), .i_WR_n(i_WR_n), .i_A(i_A), .i_CPU_DO(i_CPU_DO),
      .o_CPU_DI(o_CPU_DI), .o_DI_OE(o_DI_OE), .i_LD_EN(i_LD_EN), .i_LD_WE(i_LD_WE),
      .i_LD_ADDR(i_LD_ADDR), .i_LD_DATA(i_LD_DATA), .o_LD_ACK(o_LD_ACK),
`ifdef IKA87AD_BUSMEM_STATS_EN
      .o_RD_CNT(o_RD_CNT), .o_WR_CNT(o_WR_CNT),
`endif
      .o_WPROT(o_WPROT));

   ika87ad_busmem #(.AW(9), .PRESCALE(1), .ROM_LO(0), .ROM_HI(255)) u_dut_p1 (
      .i_EMUCLK(i_EMUCLK), .i_RESET_n(i_RESET_n), .o_PCEN(p1_PCEN), .i_ALE(i_ALE),
      .i_RD_n(i_RD_n), .i_WR_n(i_WR_n), .i_A(i_A), .i_CPU_DO(i_CPU_DO),
      .o_CPU_DI(p1_CPU_DI), .o_DI_OE(p1_DI_OE), .i_LD_EN(i_LD_EN), .i_LD_WE(i_LD_WE),
      .i_LD_ADDR(i_LD_ADDR), .i_LD_DATA(i_LD_DATA), .o_LD_ACK(p1_LD_ACK),
`ifdef IKA87AD_BUSMEM_STATS_EN
      .o_RD_CNT(p1_RD_CNT), .o_WR_CNT(p1_WR_CNT),
`endif
      .o_WPROT(p1_WPROT));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge i_EMUCLK);
      #1;
   endtask

   task automatic load(input logic [8:0] a, input logic [7:0] d);
      i_LD_ADDR = a;
      i_LD_DATA = d;
      i_LD_WE = 1'b1;
      step;
      chk("ld_ack", o_LD_ACK, 1);
      i_LD_WE = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] e);
      i_A = a;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_RD_n = 1'b0;
      step;
      chk("rd_data", o_CPU_DI, e);
      chk("rd_oe", o_DI_OE, 1);
      i_RD_n = 1'b1;
      step;
      chk("rd_idle", {o_DI_OE, o_CPU_DI}, 9'h0FF);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic p);
      i_A = a;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_WR_n = 1'b0;
      i_CPU_DO = d;
      step;
      i_WR_n = 1'b1;
      step;
      chk("wr_wprot", o_WPROT, p);
      step;
      chk("wr_wprot_end", o_WPROT, 0);
   endtask

   initial begin
      repeat (3) step;
      chk("rst_pcen", o_PCEN, 0);
      chk("rst_pcen_p1", p1_PCEN, 0);
      chk("rst_di", o_CPU_DI, 8'hFF);
      chk("rst_flags", {o_DI_OE, o_LD_ACK, o_WPROT}, 0);
      i_RESET_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step;
         chk("pcen4", o_PCEN, (k % 4 == 0));
         chk("pcen1", p1_PCEN, 1);
      end
      i_LD_EN = 1'b1;
      load(9'h100, 8'hA5);
      load(9'h010, 8'h3C);
      load(9'h181, 8'hC3);
      step;
      chk("ld_ack_idle", o_LD_ACK, 0);
      i_LD_EN = 1'b0;
      i_LD_WE = 1'b1;
      i_LD_ADDR = 9'h100;
      i_LD_DATA = 8'h00;
      step;
      chk("ld_we_no_en", o_LD_ACK, 0);
      i_LD_WE = 1'b0;
      rd(16'hFF00, 8'hA5);
      i_A = 16'h0180;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_WR_n = 1'b0;
      i_CPU_DO = 8'h11;
      step;
      i_CPU_DO = 8'h22;
      step;
      i_CPU_DO = 8'h5A;
      i_RD_n = 1'b0;
      step;
      chk("rdwr_oe", o_DI_OE, 0);
      i_RD_n = 1'b1;
      i_CPU_DO = 8'h00;
      i_WR_n = 1'b1;
      step;
      chk("wr_ram_wprot", o_WPROT, 0);
      rd(16'h0180, 8'h5A);
      wr(16'h0010, 8'h77, 1'b1);
      rd(16'h0010, 8'h3C);
      i_LD_EN = 1'b1;
      i_RD_n = 1'b0;
      step;
      chk("ld_blk_rd", {o_DI_OE, o_CPU_DI}, 9'h0FF);
      i_RD_n = 1'b1;
      i_WR_n = 1'b0;
      i_CPU_DO = 8'h55;
      step;
      i_WR_n = 1'b1;
      step;
      chk("ld_blk_wprot", o_WPROT, 0);
      i_A = 16'h0180;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_WR_n = 1'b0;
      i_CPU_DO = 8'h66;
      step;
      i_LD_EN = 1'b0;
      i_WR_n = 1'b1;
      step;
      rd(16'h0180, 8'h66);
      rd(16'h0010, 8'h3C);
      i_A = 16'hFF00;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_RD_n = 1'b0;
      step;
      chk("pre_rst_rd", o_CPU_DI, 8'hA5);
      i_RESET_n = 1'b0;
      #1;
      chk("rst_rd_drop", {o_DI_OE, o_CPU_DI}, 9'h0FF);
      i_RD_n = 1'b1;
      step;
      i_RESET_n = 1'b1;
      step;
      i_A = 16'h0181;
      i_ALE = 1'b1;
      step;
      i_ALE = 1'b0;
      i_WR_n = 1'b0;
      i_CPU_DO = 8'h99;
      step;
      step;
      i_RESET_n = 1'b0;
      #1;
      chk("rst_wr_out", {o_DI_OE, o_LD_ACK, o_WPROT, o_CPU_DI}, 11'h0FF);
      i_WR_n = 1'b1;
      step;
      i_RESET_n = 1'b1;
      step;
      chk("rst_wr_wprot", o_WPROT, 0);
      step;
      rd(16'h0181, 8'hC3);
      rd(16'hFF00, 8'hA5);
      rd(16'h0010, 8'h3C);
      i_LD_EN = 1'b1;
      i_RD_n = 1'b0;
      step;
      i_RD_n = 1'b1;
      step;
      i_LD_EN = 1'b0;
      wr(16'h0180, 8'h5A, 1'b0);
      wr(16'h0010, 8'h77, 1'b1);
`ifdef IKA87AD_BUSMEM_STATS_EN
      chk("rd_cnt", o_RD_CNT, 3);
      chk("wr_cnt", o_WR_CNT, 2);
`endif
      rd(16'h0180, 8'h5A);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ika87ad_busmem.md
Name: ika87ad_busmem

Overview:
- Synthesizable, parametrised model of the external memory on the IKA87AD bus. It replaces the ad-hoc combinational memory and prescaler used around the core.
- Generates the core's clock-enable from i_EMUCLK.
- Latches the address on ALE and serves reads with a registered path.
- Commits writes on the WR_n rising edge and write-protects a ROM window.
- Provides a loader port so the image can be written before or while the core is held off.

Parameters:
- AW, 9: implemented address bits; depth 2^AW bytes; i_A[15:AW] ignored, so memory aliases.
- PRESCALE, 4: i_EMUCLK cycles per o_PCEN pulse; legal range 1..16.
- ROM_LO, 0: first byte address of the write-protected window (AW-bit).
- ROM_HI, 255: last byte address of the write-protected window (AW-bit); ROM_LO > ROM_HI disables protection.

Ports:
- i_EMUCLK  in  1  master clock, all state on rising edge
- i_RESET_n  in  1  asynchronous active-low reset
- o_PCEN  out  1  clock-enable to core i_MCUCLK_PCEN
- i_ALE  in  1  address latch enable from core
- i_RD_n  in  1  read strobe, active low
- i_WR_n  in  1  write strobe, active low
- i_A  in  16  address from core
- i_CPU_DO  in  8  write data from core
- o_CPU_DI  out  8  read data to core
- o_DI_OE  out  1  high while o_CPU_DI is valid
- i_LD_EN  in  1  loader owns memory; core accesses are blocked
- i_LD_WE  in  1  loader write strobe, one cycle per byte
- i_LD_ADDR  in  AW  loader address
- i_LD_DATA  in  8  loader data
- o_LD_ACK  out  1  one-cycle pulse, loader byte written
- o_WPROT  out  1  one-cycle pulse, core write to ROM window discarded

Behaviour:
- Reset values: o_PCEN=0, o_CPU_DI=8'hFF, o_DI_OE=0, o_LD_ACK=0, o_WPROT=0.
  - Prescaler count=0, address latch=0, write-data register=0, WR_n history=1.
  - Memory array is NOT cleared.
- Prescaler:
  - Counter 0..PRESCALE-1, wrapping to 0.
  - o_PCEN registered, high for exactly the one cycle where count==PRESCALE-1.
  - PRESCALE=1: o_PCEN=1 every cycle from the first clock after reset release.
- Address latch: every cycle with i_ALE=1, latch <= i_A[AW-1:0]. With ALE=0 the latch holds. All core accesses use the latch.
- Read (core):
  - When i_RD_n=0, i_WR_n=1 and i_LD_EN=0 are sampled, the next cycle gives o_CPU_DI=mem[latch] and o_DI_OE=1. Latency is one EMUCLK.
  - The data tracks latch or memory changes one cycle later.
  - Otherwise, next cycle: o_CPU_DI=8'hFF, o_DI_OE=0.
- Write (core):
  - While i_WR_n=0, the write-data register captures i_CPU_DO every cycle.
  - A 0->1 transition of i_WR_n (history==0, current==1) commits the last captured byte to mem[latch] in that cycle.
  - If latch is in [ROM_LO,ROM_HI], the write is discarded and o_WPROT pulses for one cycle.
- RD_n and WR_n both low: treated as a write; o_DI_OE=0.
- Loader:
  - While i_LD_EN=1, all core reads return FF/OE=0 and core write commits are dropped, with no o_WPROT.
  - A WR_n rising edge in the first cycle after LD_EN falls still commits.
  - i_LD_WE=1 with i_LD_EN=1 writes mem[i_LD_ADDR]=i_LD_DATA, ignoring ROM protection; o_LD_ACK=1 on the next cycle.
  - i_LD_WE with LD_EN=0 is ignored, with no ACK.
  - Back-to-back LD_WE is legal, one byte per cycle.
- Reset asserted mid-access:
  - A pending WR_n-low phase is abandoned; no commit on release, since history resets to 1.
  - The read output drops to FF/0 immediately.

Optional Feature:
- Macro IKA87AD_BUSMEM_STATS_EN.
- Defined:
  - Adds output ports o_RD_CNT[15:0] and o_WR_CNT[15:0], reset to 0.
  - o_RD_CNT increments on each RD_n falling edge accepted as a read (LD_EN=0, WR_n=1).
  - o_WR_CNT increments on each committed core write, including protected-discarded ones.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, PRESCALE=4: o_PCEN=0 through reset, then pulses on the 4th, 8th, 12th EMUCLK after release. Rerun with PRESCALE=1: o_PCEN=1 from the first clock after release.
- Loader writes 8'hA5 to addr 9'h100 and 8'h3C to 9'h010 with LD_EN=1 -> o_LD_ACK pulses once per byte. Then LD_EN=0, ALE with i_A=16'hFF00 (alias of 9'h100), RD_n low -> o_CPU_DI=8'hA5, o_DI_OE=1 one cycle after RD_n falls.
- Core write of 8'h5A to i_A=16'h0180 (outside ROM), WR_n low 3 cycles with data changing 11->22->5A -> mem[9'h180]=8'h5A committed on WR_n rise; o_WPROT stays 0; readback gives 8'h5A.
- Core write of 8'h77 to i_A=16'h0010 (inside ROM window) -> o_WPROT one-cycle pulse; readback still 8'h3C.
- Reset asserted while WR_n low to addr 16'h0181 with data 8'h99, then released with WR_n high -> no write occurs; mem[9'h181] keeps its prior value; outputs at reset values.
- With IKA87AD_BUSMEM_STATS_EN defined: 3 reads, 2 writes (1 protected), plus 1 core read while LD_EN=1 -> o_RD_CNT=3, o_WR_CNT=2.
